sdma_arbiter: RTL and testbench

SDMA_ARBITER -- requirements
Module: sdma_arbiter

---
 rtl/sdma_arbiter_pkg.sv | 21 ++
 rtl/sdma_rr_pick.sv | 36 +++
 rtl/sdma_arbiter.sv | 152 +++++++++++++++
 tb/tb_sdma_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdma_arbiter_pkg.sv
// Shared definitions for the SDMA arbiter: FSM state encoding, counter width
// and the default transfer timeout.
package sdma_arbiter_pkg;

    localparam int unsigned TIMEOUT_DEFAULT = 1000;
    localparam int unsigned CNT_W           = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_ACTIVE = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERR    = 3'd4
    } state_e;

    // A channel owns the SDMA (grant held, timeout running) only in these states.
    function automatic logic is_busy(state_e s);
        return (s == ST_REQ) || (s == ST_ACTIVE);
    endfunction

endpackage

// File: rtl/sdma_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req_i   - request vector, one bit per channel
//   last_i  - index of the channel served last; search starts at last_i+1
//   valid_o - at least one request present
//   index_o - first requesting channel after last_i, wrapping modulo N
module sdma_rr_pick
#(
    parameter int unsigned N = 4
)
(
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] last_i,
    output logic                 valid_o,
    output logic [$clog2(N)-1:0] index_o
);

    localparam int unsigned W = $clog2(N);

    logic [W-1:0] cand;

    // Walk the channels in priority order and keep the first requester.
    always_comb begin
        valid_o = 1'b0;
        index_o = '0;
        cand    = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = W'((32'(last_i) + k) % N);
            if (!valid_o && req_i[cand]) begin
                valid_o = 1'b1;
                index_o = cand;
            end
        end
    end

endmodule

// File: rtl/sdma_arbiter.sv
// Arbitrates NUM_CH requesting channels onto a single SDMA controller.
// A channel is chosen round-robin, the SDMA is requested on its behalf, and the
// transfer ends either with a completion (ch_done + sdma_irq pulse) or with a
// timeout abort (timeout_err pulse). All outputs are registered.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   ch_req       - per-channel level request
//   ch_grant     - one-hot grant to the owning channel (zero when none)
//   ch_sel       - index of the granted channel, valid while ch_grant != 0
//   ch_done      - one-cycle completion pulse to the served channel
//   sdma_req     - request to the SDMA controller
//   sdma_active  - controller has accepted the request
//   sdma_done    - one-cycle completion pulse from the controller
//   sdma_irq     - one-cycle pulse per successful completion
//   timeout_err  - one-cycle pulse per aborted transfer
module sdma_arbiter
    import sdma_arbiter_pkg::*;
#(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
)
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         ch_req,
    output logic [NUM_CH-1:0]         ch_grant,
    output logic [$clog2(NUM_CH)-1:0] ch_sel,
    output logic [NUM_CH-1:0]         ch_done,
    output logic                      sdma_req,
    input  logic                      sdma_active,
    input  logic                      sdma_done,
    output logic                      sdma_irq,
    output logic                      timeout_err
);

    localparam int unsigned SEL_W = $clog2(NUM_CH);

    state_e              state_q, state_d;
    logic [NUM_CH-1:0]   grant_q, grant_d;
    logic [NUM_CH-1:0]   done_q, done_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [SEL_W-1:0]    last_q, last_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                req_q, req_d;
    logic                irq_q, irq_d;
    logic                err_q, err_d;
    logic                pick_valid;
    logic [SEL_W-1:0]    pick_idx;
    logic                timeout_hit;

    sdma_rr_pick #(
        .N       (NUM_CH)
    ) u_rr_pick (
        .req_i   (ch_req),
        .last_i  (last_q),
        .valid_o (pick_valid),
        .index_o (pick_idx)
    );

    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    // Next-state: completion beats acceptance, and any progress beats the timeout.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_REQ;
                    sel_d   = pick_idx;
                end
            end
            ST_REQ: begin
                if (sdma_done) begin
                    state_d = ST_DONE;
                end else if (sdma_active) begin
                    state_d = ST_ACTIVE;
                end else if (timeout_hit) begin
                    state_d = ST_ERR;
                end
            end
            ST_ACTIVE: begin
                if (sdma_done) begin
                    state_d = ST_DONE;
                end else if (timeout_hit) begin
                    state_d = ST_ERR;
                end
            end
            ST_DONE, ST_ERR: begin
                state_d = ST_IDLE;
                last_d  = sel_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered outputs are a function of the state being entered.
    always_comb begin
        grant_d = '0;
        done_d  = '0;
        req_d   = 1'b0;
        irq_d   = 1'b0;
        err_d   = 1'b0;
        cnt_d   = '0;
        if (is_busy(state_d)) begin
            grant_d = NUM_CH'(1) << sel_d;
            // Counter restarts on every entry into REQ or ACTIVE.
            cnt_d   = (state_d == state_q) ? cnt_q + CNT_W'(1) : '0;
        end
        req_d = (state_d == ST_REQ);
        if (state_d == ST_DONE) begin
            done_d = NUM_CH'(1) << sel_d;
            irq_d  = 1'b1;
        end
        err_d = (state_d == ST_ERR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            done_q  <= '0;
            sel_q   <= '0;
            last_q  <= SEL_W'(NUM_CH - 1);
            cnt_q   <= '0;
            req_q   <= 1'b0;
            irq_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            irq_q   <= irq_d;
            err_q   <= err_d;
        end
    end

    assign ch_grant    = grant_q;
    assign ch_sel      = sel_q;
    assign ch_done     = done_q;
    assign sdma_req    = req_q;
    assign sdma_irq    = irq_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_sdma_arbiter.sv
// Bench for sdma_arbiter: directed scenarios with literal expectations plus a
// randomized phase, all compared every cycle against a transaction-level model.
module tb_sdma_arbiter;

    localparam int NCH = 4;
    localparam int TMO = 10;

    logic            clk = 1'b0;
    logic            rst;
    logic [NCH-1:0]  ch_req;
    logic [NCH-1:0]  ch_grant;
    logic [1:0]      ch_sel;
    logic [NCH-1:0]  ch_done;
    logic            sdma_req;
    logic            sdma_active;
    logic            sdma_done;
    logic            sdma_irq;
    logic            timeout_err;

    int checks = 0;
    int errors = 0;

    sdma_arbiter #(
        .NUM_CH      (NCH),
        .TIMEOUT     (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ch_req      (ch_req),
        .ch_grant    (ch_grant),
        .ch_sel      (ch_sel),
        .ch_done     (ch_done),
        .sdma_req    (sdma_req),
        .sdma_active (sdma_active),
        .sdma_done   (sdma_done),
        .sdma_irq    (sdma_irq),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: who owns the SDMA, whether it is still waiting for acceptance,
    // how long it has been waiting, and a one-cycle cool-down after each end.
    int             m_owner = -1;
    bit             m_wait  = 1'b0;
    int             m_age   = 0;
    int             m_last  = NCH - 1;
    bit             m_cool  = 1'b0;
    int             m_sel   = 0;
    logic [NCH-1:0] e_grant = '0;
    logic [NCH-1:0] e_done  = '0;
    bit             e_req   = 1'b0;
    bit             e_irq   = 1'b0;
    bit             e_err   = 1'b0;

    initial forever begin
        @(posedge clk or posedge rst);
        e_done = '0;
        e_irq  = 1'b0;
        e_err  = 1'b0;
        if (rst) begin
            m_owner = -1;
            m_wait  = 1'b0;
            m_age   = 0;
            m_last  = NCH - 1;
            m_cool  = 1'b0;
            m_sel   = 0;
        end else if (m_owner >= 0) begin
            if (sdma_done) begin
                e_done[m_owner] = 1'b1;
                e_irq   = 1'b1;
                m_last  = m_owner;
                m_owner = -1;
                m_cool  = 1'b1;
            end else if (m_wait && sdma_active) begin
                m_wait = 1'b0;
                m_age  = 0;
            end else if (m_age == TMO - 1) begin
                e_err   = 1'b1;
                m_last  = m_owner;
                m_owner = -1;
                m_cool  = 1'b1;
            end else begin
                m_age++;
            end
        end else if (m_cool) begin
            m_cool = 1'b0;
        end else if (ch_req != '0) begin
            for (int k = 1; k <= NCH; k++) begin
                if (m_owner < 0 && ch_req[(m_last + k) % NCH]) m_owner = (m_last + k) % NCH;
            end
            m_wait = 1'b1;
            m_age  = 0;
            m_sel  = m_owner;
        end
        e_grant = '0;
        if (m_owner >= 0) e_grant[m_owner] = 1'b1;
        e_req = (m_owner >= 0) && m_wait;
    end

    // Per-cycle comparison, sampled after the active edge has settled.
    initial forever begin
        @(posedge clk);
        #2;
        check("grant", 32'(ch_grant), 32'(e_grant));
        check("sdma_req", 32'(sdma_req), 32'(e_req));
        check("ch_done", 32'(ch_done), 32'(e_done));
        check("sdma_irq", 32'(sdma_irq), 32'(e_irq));
        check("timeout_err", 32'(timeout_err), 32'(e_err));
        if (e_grant != '0) check("ch_sel", 32'(ch_sel), 32'(m_sel));
    end

    task automatic do_reset();
        rst         = 1'b1;
        ch_req      = '0;
        sdma_active = 1'b0;
        sdma_done   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Counts grant-free negedges starting at the current one; bounded.
    task automatic wait_grant(output int gap);
        gap = 0;
        while (ch_grant == '0 && gap < 100) begin
            gap++;
            @(negedge clk);
        end
        check("grant_seen", 32'(ch_grant != '0), 32'd1);
    endtask

    task automatic serve();
        sdma_active = 1'b1;
        @(negedge clk);
        sdma_active = 1'b0;
        sdma_done   = 1'b1;
        @(negedge clk);
        sdma_done   = 1'b0;
    endtask

    initial begin
        int gap;
        int n;
        rst         = 1'b1;
        ch_req      = '0;
        sdma_active = 1'b0;
        sdma_done   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_grant", 32'(ch_grant), 32'd0);
        check("rst_sel", 32'(ch_sel), 32'd0);
        check("rst_sdma_req", 32'(sdma_req), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic transfer, round-robin from ch0 picks ch1 of 0110.
        ch_req = 4'b0110;
        @(negedge clk);
        check("s1_grant", 32'(ch_grant), 32'h2);
        check("s1_req", 32'(sdma_req), 32'd1);
        check("s1_sel", 32'(ch_sel), 32'd1);
        sdma_active = 1'b1;
        @(negedge clk);
        check("s1_req_low", 32'(sdma_req), 32'd0);
        sdma_active = 1'b0;
        sdma_done   = 1'b1;
        @(negedge clk);
        sdma_done = 1'b0;
        ch_req    = '0;
        check("s1_done", 32'(ch_done), 32'h2);
        check("s1_irq", 32'(sdma_irq), 32'd1);
        check("s1_grant_off", 32'(ch_grant), 32'd0);
        @(negedge clk);
        check("s1_irq_once", 32'(sdma_irq), 32'd0);

        // All channels requesting: order 0,1,2,3,0 with two empty cycles between.
        do_reset();
        ch_req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            wait_grant(gap);
            check("s2_order", 32'(ch_grant), 32'd1 << (t % 4));
            if (t > 0) check("s2_gap", 32'(gap), 32'd2);
            serve();
        end
        ch_req = '0;
        repeat (3) @(negedge clk);

        // Never accepted: abort after TMO request cycles, next channel follows.
        do_reset();
        ch_req = 4'b1111;
        wait_grant(gap);
        check("s3_first", 32'(ch_grant), 32'h1);
        n = 0;
        while (sdma_req && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("s3_req_cycles", 32'(n), 32'(TMO));
        check("s3_err", 32'(timeout_err), 32'd1);
        check("s3_no_irq", 32'(sdma_irq), 32'd0);
        wait_grant(gap);
        check("s3_next", 32'(ch_grant), 32'h2);
        ch_req = '0;
        repeat (TMO + 5) @(negedge clk);

        // Done and active together while requesting.
        do_reset();
        ch_req = 4'b0100;
        wait_grant(gap);
        check("s4_grant", 32'(ch_grant), 32'h4);
        sdma_active = 1'b1;
        sdma_done   = 1'b1;
        @(negedge clk);
        sdma_active = 1'b0;
        sdma_done   = 1'b0;
        ch_req      = '0;
        check("s4_done", 32'(ch_done), 32'h4);
        check("s4_irq", 32'(sdma_irq), 32'd1);
        @(negedge clk);
        check("s4_irq_once", 32'(sdma_irq), 32'd0);

        // Reset during a transfer clears outputs immediately, ch0 wins afterwards.
        do_reset();
        ch_req = 4'b1000;
        wait_grant(gap);
        check("s5_grant", 32'(ch_grant), 32'h8);
        sdma_active = 1'b1;
        @(negedge clk);
        sdma_active = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("s5_async_grant", 32'(ch_grant), 32'd0);
        check("s5_async_req", 32'(sdma_req), 32'd0);
        check("s5_async_pulses", 32'({ch_done, sdma_irq, timeout_err}), 32'd0);
        @(negedge clk);
        rst    = 1'b0;
        ch_req = 4'b1111;
        wait_grant(gap);
        check("s5_first", 32'(ch_grant), 32'h1);
        ch_req = '0;
        repeat (TMO + 5) @(negedge clk);

        // Randomized traffic, checked by the model every cycle.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 699) == 0) rst = 1'b1;
            if ($urandom_range(0, 9) < 7) ch_req = 4'($urandom);
            sdma_active = ($urandom_range(0, 3) == 0);
            sdma_done   = ($urandom_range(0, 5) == 0);
        end
        rst         = 1'b0;
        ch_req      = '0;
        sdma_active = 1'b0;
        sdma_done   = 1'b0;
        repeat (TMO + 5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
